jtbubl_snd_mix: RTL and testbench



---
 rtl/jtbubl_snd_pkg.sv | 41 ++++
 rtl/jtbubl_snd_lpf.sv | 33 +++
 rtl/jtbubl_snd_mix.sv | 210 +++++++++++++++++++++
 tb/tb_jtbubl_snd_mix.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_snd_pkg.sv
// Shared types and constants for the jtbubl sound mixer.
// The optional low-pass stage is enabled with `define JTBUBL_SND_LPF_EN.
package jtbubl_snd_pkg;

    localparam int ACC_W   = 26;
    localparam int PSG_MID = 512;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC0,
        ST_MAC1,
        ST_MAC2,
        ST_MASTER,
        ST_SAT,
        ST_FILT
    } state_t;

    typedef struct packed {
        logic [15:0] fm;
        logic [15:0] opn;
        logic [9:0]  psg;
        logic        en_fm;
        logic        en_psg;
        logic [1:0]  fxlevel;
    } mix_in_t;

    // Master gain in Q3: 0.5 / 0.75 / 1.0 / 1.5
    function automatic logic [3:0] fx_gain(input logic [1:0] sel);
        logic [3:0] g;
        case (sel)
            2'd0:    g = 4'd4;
            2'd1:    g = 4'd6;
            2'd2:    g = 4'd8;
            default: g = 4'd12;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/jtbubl_snd_lpf.sv
// First-order low-pass stage y += (x - y) >>> 2, updated only while en is high.
// Instantiated by jtbubl_snd_mix when JTBUBL_SND_LPF_EN is defined.
module jtbubl_snd_lpf (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic signed [15:0] y_q, y_d;
    logic signed [16:0] diff;

    // The step always moves y toward x, so the sum cannot leave 16-bit range
    always_comb begin
        diff = 17'(x) - 17'(y_q);
        y_d  = y_q;
        if (en) begin
            y_d = y_q + 16'(diff >>> 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/jtbubl_snd_mix.sv
// Serial MAC mixer for YM3526 FM, YM2203 FM and YM2203 PSG with master gain and saturation.
// Define JTBUBL_SND_LPF_EN to add the FILT state and the jtbubl_snd_lpf output filter.
module jtbubl_snd_mix
    import jtbubl_snd_pkg::*;
#(
    parameter logic [7:0] FM_GAIN  = 8'h10,
    parameter logic [7:0] OPN_GAIN = 8'h10,
    parameter logic [7:0] PSG_GAIN = 8'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_in,
    input  logic signed [15:0] fm_snd,
    input  logic signed [15:0] opn_fm,
    input  logic [9:0]         opn_psg,
    input  logic               enable_fm,
    input  logic               enable_psg,
    input  logic [1:0]         fxlevel,
    output logic signed [15:0] snd,
    output logic               sample,
    output logic               busy,
    output logic               overrun
);

    state_t                   state_q, state_d;
    logic                     start_q, start_d;
    mix_in_t                  work_q, work_d;
    mix_in_t                  pend_q, pend_d;
    logic                     pv_q, pv_d;
    logic                     ovr_q, ovr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     sample_q, sample_d;

    mix_in_t                  in_now;
    logic                     busy_any;
    logic                     take_pend;
    logic [9:0]               psg_diff;
    logic signed [15:0]       fm_ch, opn_ch, psg_ch, mac_ch;
    logic [7:0]               mac_gain;
    logic signed [24:0]       mac_prod;
    logic signed [21:0]       acc_sh;
    logic signed [26:0]       master_prod;
    logic signed [15:0]       sat_val;

`ifdef JTBUBL_SND_LPF_EN
    logic signed [15:0]       sat_q, sat_d;
    logic signed [15:0]       lpf_y;
`else
    logic signed [15:0]       snd_q, snd_d;
`endif

    assign in_now = '{fm: fm_snd, opn: opn_fm, psg: opn_psg,
                      en_fm: enable_fm, en_psg: enable_psg, fxlevel: fxlevel};

    // start_q marks the cycle between capture and MAC0; the FSM is already committed then
    assign busy_any  = (state_q != ST_IDLE) || start_q;
    assign take_pend = (state_q == ST_IDLE) && !start_q && pv_q;

    always_comb begin
        psg_diff = work_q.psg - 10'(PSG_MID);
        fm_ch    = work_q.en_fm  ? $signed(work_q.fm)  : 16'sd0;
        opn_ch   = work_q.en_fm  ? $signed(work_q.opn) : 16'sd0;
        psg_ch   = work_q.en_psg ? $signed({psg_diff, 6'b0}) : 16'sd0;
        mac_ch   = fm_ch;
        mac_gain = FM_GAIN;
        case (state_q)
            ST_MAC1: begin
                mac_ch   = opn_ch;
                mac_gain = OPN_GAIN;
            end
            ST_MAC2: begin
                mac_ch   = psg_ch;
                mac_gain = PSG_GAIN;
            end
            default: ;
        endcase
        mac_prod    = mac_ch * $signed({1'b0, mac_gain});
        acc_sh      = acc_q[ACC_W-1:4];
        master_prod = acc_sh * $signed({1'b0, fx_gain(work_q.fxlevel)});
        if (acc_q > ACC_W'(SAT_MAX)) begin
            sat_val = 16'(SAT_MAX);
        end else if (acc_q < ACC_W'(SAT_MIN)) begin
            sat_val = 16'(SAT_MIN);
        end else begin
            sat_val = acc_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        work_d   = work_q;
        pend_d   = pend_q;
        pv_d     = pv_q;
        ovr_d    = ovr_q;
        acc_d    = acc_q;
        sample_d = 1'b0;
`ifdef JTBUBL_SND_LPF_EN
        sat_d    = sat_q;
`else
        snd_d    = snd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_MAC0;
                    acc_d   = '0;
                end else if (pv_q) begin
                    work_d  = pend_q;
                    pv_d    = 1'b0;
                    start_d = 1'b1;
                end else if (sample_in) begin
                    work_d  = in_now;
                    start_d = 1'b1;
                end
            end
            ST_MAC0: begin
                acc_d   = acc_q + ACC_W'(mac_prod);
                state_d = ST_MAC1;
            end
            ST_MAC1: begin
                acc_d   = acc_q + ACC_W'(mac_prod);
                state_d = ST_MAC2;
            end
            ST_MAC2: begin
                acc_d   = acc_q + ACC_W'(mac_prod);
                state_d = ST_MASTER;
            end
            ST_MASTER: begin
                acc_d   = ACC_W'(master_prod >>> 3);
                state_d = ST_SAT;
            end
`ifdef JTBUBL_SND_LPF_EN
            ST_SAT: begin
                sat_d   = sat_val;
                state_d = ST_FILT;
            end
            ST_FILT: begin
                sample_d = 1'b1;
                state_d  = ST_IDLE;
            end
`else
            ST_SAT: begin
                snd_d    = sat_val;
                sample_d = 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // A strobe in the pending-load cycle refills the buffer without counting as an overrun
        if (sample_in && (busy_any || take_pend)) begin
            pend_d = in_now;
            pv_d   = 1'b1;
            if (pv_q && !take_pend) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            work_q   <= '0;
            pend_q   <= '0;
            pv_q     <= 1'b0;
            ovr_q    <= 1'b0;
            acc_q    <= '0;
            sample_q <= 1'b0;
`ifdef JTBUBL_SND_LPF_EN
            sat_q    <= '0;
`else
            snd_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            work_q   <= work_d;
            pend_q   <= pend_d;
            pv_q     <= pv_d;
            ovr_q    <= ovr_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
`ifdef JTBUBL_SND_LPF_EN
            sat_q    <= sat_d;
`else
            snd_q    <= snd_d;
`endif
        end
    end

`ifdef JTBUBL_SND_LPF_EN
    jtbubl_snd_lpf u_lpf (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_FILT),
        .x   (sat_q),
        .y   (lpf_y)
    );
    assign snd = lpf_y;
`else
    assign snd = snd_q;
`endif

    assign sample  = sample_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_jtbubl_snd_mix.sv
// Directed scoreboard bench for jtbubl_snd_mix; expected results are queued at strobe time.
// Follows JTBUBL_SND_LPF_EN to select latency and the filtered reference.
module tb_jtbubl_snd_mix;

`ifdef JTBUBL_SND_LPF_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_in;
    logic signed [15:0] fm_snd;
    logic signed [15:0] opn_fm;
    logic [9:0]         opn_psg;
    logic               enable_fm;
    logic               enable_psg;
    logic [1:0]         fxlevel;
    logic signed [15:0] snd;
    logic               sample;
    logic               busy;
    logic               overrun;

    typedef struct {
        int fm;
        int opn;
        int psg;
        bit efm;
        bit epsg;
        int fxl;
    } vec_t;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   lpf_y       = 0;
    int   last_val    = 0;

    jtbubl_snd_mix dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .fm_snd     (fm_snd),
        .opn_fm     (opn_fm),
        .opn_psg    (opn_psg),
        .enable_fm  (enable_fm),
        .enable_psg (enable_psg),
        .fxlevel    (fxlevel),
        .snd        (snd),
        .sample     (sample),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic int mix_ref(input vec_t v);
        int fx[4] = '{4, 6, 8, 12};
        int acc = 0;
        if (v.efm) acc += v.fm * 16 + v.opn * 16;
        if (v.epsg) acc += (v.psg - 512) * 64 * 8;
        acc = ((acc >>> 4) * fx[v.fxl]) >>> 3;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic int filter_ref(input int raw);
`ifdef JTBUBL_SND_LPF_EN
        lpf_y = lpf_y + ((raw - lpf_y) >>> 2);
`else
        lpf_y = raw;
`endif
        return lpf_y;
    endfunction

    task automatic applyStimulus(input vec_t v, output int edge_no);
        fm_snd     = 16'(v.fm);
        opn_fm     = 16'(v.opn);
        opn_psg    = 10'(v.psg);
        enable_fm  = v.efm;
        enable_psg = v.epsg;
        fxlevel    = 2'(v.fxl);
        sample_in  = 1'b1;
        edge_no    = cyc + 1;
        @(negedge clk);
        sample_in  = 1'b0;
    endtask

    task automatic expectMix(input vec_t v, input int edge_no);
        exp_t e;
        e.val    = filter_ref(mix_ref(v));
        e.cyc    = edge_no + LAT;
        last_val = e.val;
        exp_q.push_back(e);
    endtask

    task automatic runOne(input vec_t v);
        int e;
        applyStimulus(v, e);
        expectMix(v, e);
        repeat (LAT + 2) @(negedge clk);
        checkOutput("snd_hold", 32'(snd), last_val);
    endtask

    // Scoreboard monitor: a pulse must appear exactly on the queued edge and nowhere else
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checkOutput("missed_pulse", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            checkOutput("sample_pulse", 32'(sample), 1);
            checkOutput("snd_value", 32'(snd), exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            checkOutput("sample_idle", 32'(sample), 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        vec_t a;
        vec_t b;
        vec_t c;
        int   e;
        int   t;

        // Reset with a strobe on the first edge: nothing may come out
        rst        = 1'b1;
        sample_in  = 1'b1;
        fm_snd     = 16'sd1000;
        opn_fm     = 16'sd0;
        opn_psg    = 10'd512;
        enable_fm  = 1'b1;
        enable_psg = 1'b1;
        fxlevel    = 2'd2;
        @(negedge clk);
        sample_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_snd", 32'(snd), 0);
        checkOutput("rst_sample", 32'(sample), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        rst   = 1'b0;
        lpf_y = 0;
        repeat (8) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 0);

        // Single channel with busy timing
        v = '{fm: 1000, opn: 0, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2};
        applyStimulus(v, e);
        expectMix(v, e);
        checkOutput("busy_t0", 32'(busy), 0);
        @(negedge clk);
        checkOutput("busy_t1", 32'(busy), 1);
        repeat (LAT + 1) @(negedge clk);
        checkOutput("busy_done", 32'(busy), 0);
        checkOutput("single_hold", 32'(snd), last_val);

        // Saturation, mute and master gain
        runOne('{fm: 30000, opn: 30000, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2});
        runOne('{fm: -30000, opn: -30000, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2});
        runOne('{fm: 20000, opn: 20000, psg: 1023, efm: 1'b0, epsg: 1'b1, fxl: 3});
        runOne('{fm: 20000, opn: 20000, psg: 1023, efm: 1'b0, epsg: 1'b1, fxl: 0});
        runOne('{fm: 0, opn: 0, psg: 0, efm: 1'b1, epsg: 1'b1, fxl: 2});
        runOne('{fm: 1000, opn: 1000, psg: 700, efm: 1'b1, epsg: 1'b0, fxl: 1});

        // Buffering: A at t, B at t+2, C at t+3; B is overwritten
        a = '{fm: 1000, opn: 0, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2};
        b = '{fm: 2000, opn: 0, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2};
        c = '{fm: 3000, opn: 0, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2};
        applyStimulus(a, t);
        expectMix(a, t);
        @(negedge clk);
        applyStimulus(b, e);
        checkOutput("overrun_before", 32'(overrun), 0);
        applyStimulus(c, e);
        expectMix(c, t + 13 - LAT);
        @(negedge clk);
        checkOutput("overrun_set", 32'(overrun), 1);
        repeat (16) @(negedge clk);
        checkOutput("overrun_sticky", 32'(overrun), 1);

        // Reset mid-mix: clears overrun, abandons the mix
        applyStimulus(a, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        lpf_y = 0;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_overrun", 32'(overrun), 0);
        checkOutput("midrst_snd", 32'(snd), 0);
        repeat (10) @(negedge clk);

        // Strobe in the pending-load cycle becomes new pending data without overrun
        b = '{fm: -5000, opn: 2500, psg: 100, efm: 1'b1, epsg: 1'b1, fxl: 1};
        c = '{fm: 123, opn: -456, psg: 900, efm: 1'b1, epsg: 1'b1, fxl: 3};
        applyStimulus(a, t);
        expectMix(a, t);
        @(negedge clk);
        applyStimulus(b, e);
        expectMix(b, t + 13 - LAT);
        repeat (4) @(negedge clk);
        applyStimulus(c, e);
        expectMix(c, t + 20 - LAT);
        checkOutput("pendload_overrun", 32'(overrun), 0);
        repeat (16) @(negedge clk);
        checkOutput("pendload_overrun_end", 32'(overrun), 0);

        // Repeated step for the filter (constant 4000 without it)
        for (int i = 0; i < 4; i++) begin
            runOne('{fm: 4000, opn: 0, psg: 512, efm: 1'b1, epsg: 1'b1, fxl: 2});
        end

        for (int i = 0; i < 4; i++) begin
            v.fm   = int'($signed(16'($urandom)));
            v.opn  = int'($signed(16'($urandom)));
            v.psg  = int'($urandom_range(0, 1023));
            v.efm  = 1'($urandom_range(0, 1));
            v.epsg = 1'($urandom_range(0, 1));
            v.fxl  = int'($urandom_range(0, 3));
            runOne(v);
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
